// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline register.
package pipe_pkg;

    // Default payload is {PC, IR}
    localparam int unsigned PIPE_PC_W = 32;
    localparam int unsigned PIPE_IR_W = 32;

    // Number of beats held by the stage register
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready payload channel; master drives valid/data, slave drives ready.
interface pipe_skid_reg_if #(
    parameter int unsigned DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface : pipe_skid_reg_if

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module pipe_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Increment unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : pipe_sat_cnt

// File: rtl/pipe_skid_reg.sv
// Elastic two-entry pipeline register for a stage boundary.
// up = upstream channel (in_valid/in_ready/in_data),
// dn = downstream channel (out_valid/out_ready/out_data).
// Optional feature macro: PIPE_PERF_CNT_EN enables the stall/bubble counters;
// without it stall_cnt/bubble_cnt are tied to zero.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        DATA_W    = PIPE_PC_W + PIPE_IR_W,
    parameter logic [DATA_W-1:0]  FLUSH_VAL = '0,
    parameter int unsigned        CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    pipe_skid_reg_if.slave       up,
    pipe_skid_reg_if.master      dn,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q,  main_d;
    logic [DATA_W-1:0] skid_q,  skid_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q,  in_ready_d;

    logic accept_c;
    logic send_c;

    assign accept_c = up.valid & in_ready_q;
    assign send_c   = out_valid_q & dn.ready;

    // Next-state / datapath: main always holds the oldest beat, skid the younger one
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            PS_EMPTY: begin
                if (accept_c) begin
                    main_d  = up.data;
                    state_d = PS_ONE;
                end
            end
            PS_ONE: begin
                if (accept_c && send_c) begin
                    main_d = up.data;
                end else if (accept_c) begin
                    skid_d  = up.data;
                    state_d = PS_TWO;
                end else if (send_c) begin
                    state_d = PS_EMPTY;
                end
            end
            PS_TWO: begin
                if (send_c) begin
                    main_d  = skid_q;
                    state_d = PS_ONE;
                end
            end
            default: begin
                state_d = PS_EMPTY;
            end
        endcase

        // Flush squashes everything, including a beat accepted this cycle
        if (flush) begin
            state_d = PS_EMPTY;
            main_d  = FLUSH_VAL;
        end

        out_valid_d = (state_d != PS_EMPTY);
        in_ready_d  = (state_d != PS_TWO);
    end

    // State and datapath registers; handshake outputs are flopped, not decoded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PS_EMPTY;
            main_q      <= FLUSH_VAL;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign up.ready = in_ready_q;
    assign dn.valid = out_valid_q;
    assign dn.data  = main_q;

`ifdef PIPE_PERF_CNT_EN
    logic stall_en_c;
    logic bubble_en_c;

    assign stall_en_c  = out_valid_q & dn.ready ? 1'b0 : out_valid_q;
    assign bubble_en_c = ~out_valid_q & dn.ready;

    // Stall cycle counter
    pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_en_c),
        .cnt   (stall_cnt)
    );

    // Bubble cycle counter
    pipe_sat_cnt #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bubble_en_c),
        .cnt   (bubble_cnt)
    );
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: vector table, hand-written corner sequences and
// a randomized run against a queue-based reference model.
module tb_pipe_skid_reg;
    import pipe_pkg::*;

    localparam int unsigned DW    = 64;
    localparam int unsigned CW    = 4;
    localparam logic [DW-1:0] FV  = '0;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;

    pipe_skid_reg_if #(.DATA_W(DW)) up_if ();
    pipe_skid_reg_if #(.DATA_W(DW)) dn_if ();

    pipe_skid_reg #(
        .DATA_W    (DW),
        .FLUSH_VAL (FV),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .up         (up_if),
        .dn         (dn_if),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: held beats in arrival order, plus counters
    logic [DW-1:0] mq[$];
    bit            m_fv;       // out_data must read FLUSH_VAL while empty
    int unsigned   m_stall;
    int unsigned   m_bubble;

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          fl;
        logic          ev;
        logic          cd;     // compare data
        logic [DW-1:0] ed;
        logic          er;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_fv     = 1'b1;
        m_stall  = 0;
        m_bubble = 0;
    endfunction

    // Apply current inputs to the model as one clock edge
    function automatic void model_edge();
        int  sz  = mq.size();
        bit  snd = (sz > 0) && dn_if.ready;
        bit  acc = up_if.valid && (sz < 2);
        if (PERF) begin
            if (sz > 0 && !dn_if.ready && m_stall < CNT_MAX)   m_stall++;
            if (sz == 0 && dn_if.ready && m_bubble < CNT_MAX)  m_bubble++;
        end
        if (flush) begin
            mq.delete();
            m_fv = 1'b1;
        end else begin
            if (snd) void'(mq.pop_front());
            if (acc) mq.push_back(up_if.data);
            if (mq.size() > 0) m_fv = 1'b0;
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag);
        chk({tag, ".stall_cnt"},  DW'(stall_cnt),  DW'(m_stall));
        chk({tag, ".bubble_cnt"}, DW'(bubble_cnt), DW'(m_bubble));
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out_valid"}, DW'(dn_if.valid), DW'(mq.size() > 0));
        chk({tag, ".in_ready"},  DW'(up_if.ready), DW'(mq.size() < 2));
        if (mq.size() > 0)  chk({tag, ".out_data"}, dn_if.data, mq[0]);
        else if (m_fv)      chk({tag, ".out_data_flush"}, dn_if.data, FV);
        check_cnt(tag);
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
        up_if.valid = iv;
        up_if.data  = d;
        dn_if.ready = ordy;
        flush       = fl;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic iv, input logic [DW-1:0] d, input logic ordy,
                           input logic ev, input logic cd, input logic [DW-1:0] ed, input logic er);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = 1'b0;
        v.ev = ev; v.cd = cd; v.ed = ed; v.er = er;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);

        // Streaming 1..8, then drain
        for (int k = 1; k <= 8; k++) add_vec(1'b1, DW'(k), 1'b1, 1'b1, 1'b1, DW'(k), 1'b1);
        add_vec(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        // Back-pressure A, B, C
        add_vec(1'b1, 64'hA, 1'b0, 1'b1, 1'b1, 64'hA, 1'b1);
        add_vec(1'b1, 64'hB, 1'b0, 1'b1, 1'b1, 64'hA, 1'b0);
        add_vec(1'b1, 64'hC, 1'b0, 1'b1, 1'b1, 64'hA, 1'b0);
        add_vec(1'b1, 64'hC, 1'b0, 1'b1, 1'b1, 64'hA, 1'b0);
        add_vec(1'b1, 64'hC, 1'b1, 1'b1, 1'b1, 64'hB, 1'b1);
        add_vec(1'b1, 64'hC, 1'b1, 1'b1, 1'b1, 64'hC, 1'b1);
        add_vec(1'b0, '0,    1'b1, 1'b0, 1'b0, '0,    1'b1);

        // Reset state
        do_reset();
        chk("reset.out_valid", DW'(dn_if.valid), '0);
        chk("reset.out_data",  dn_if.data, FV);
        chk("reset.in_ready",  DW'(up_if.ready), DW'(1));
        chk("reset.stall_cnt", DW'(stall_cnt), '0);
        chk("reset.bubble_cnt", DW'(bubble_cnt), '0);

        // Vector table
        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
            step();
            chk($sformatf("vec%0d.out_valid", i), DW'(dn_if.valid), DW'(vecs[i].ev));
            chk($sformatf("vec%0d.in_ready", i),  DW'(up_if.ready), DW'(vecs[i].er));
            if (vecs[i].cd) chk($sformatf("vec%0d.out_data", i), dn_if.data, vecs[i].ed);
            check_cnt($sformatf("vec%0d", i));
        end

        // Flush while holding two beats, with a third beat offered
        do_reset();
        drive(1'b1, 64'hA, 1'b0, 1'b0); step();
        drive(1'b1, 64'hB, 1'b0, 1'b0); step();
        chk("flush.pre_ready", DW'(up_if.ready), '0);
        drive(1'b1, 64'hC, 1'b0, 1'b1); step();
        chk("flush.out_valid", DW'(dn_if.valid), '0);
        chk("flush.out_data",  dn_if.data, FV);
        chk("flush.in_ready",  DW'(up_if.ready), DW'(1));
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("flush.no_c", DW'(dn_if.valid), '0);
        end

        // Async reset between edges while holding two beats
        do_reset();
        drive(1'b1, 64'h11, 1'b0, 1'b0); step();
        drive(1'b1, 64'h22, 1'b0, 1'b0); step();
        chk("areset.pre_valid", DW'(dn_if.valid), DW'(1));
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("areset.out_valid", DW'(dn_if.valid), '0);
        chk("areset.in_ready",  DW'(up_if.ready), DW'(1));
        chk("areset.out_data",  dn_if.data, FV);
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Long stall saturates the stall counter
        do_reset();
        drive(1'b1, 64'h5A, 1'b0, 1'b0); step();
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("stall.hold_data", dn_if.data, 64'h5A);
        end
        chk("stall.stall_sat", DW'(stall_cnt), PERF ? DW'(CNT_MAX) : '0);
        chk("stall.bubble",    DW'(bubble_cnt), '0);
        check_model("stall");

        // Randomized run against the model; flush does not clear counters
        for (int k = 0; k < 2000; k++) begin
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom},
                  $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
            step();
            check_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_skid_reg
